icache: RTL and testbench

- Direct-mapped instruction cache between the IF stage and memctrl's instruction port.
- Accepts word-fetch requests from IF. Returns hits with 1-cycle latency.
- On a miss, refills from memctrl, writes the line, then answers IF.
- Uses the same handshake style as the existing memctrl IF interface (get/address in, done/data out).

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_if.sv | 31 +++
 rtl/icache_array.sv | 53 +++++
 rtl/icache.sv | 143 ++++++++++++++
 tb/tb_icache.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared parameters, types and FSM encoding for the
// direct-mapped instruction cache.
//
// Geometry: 2^INDEX_BITS lines of one 32-bit word each. Only address
// bits [ADDR_USED-1:0] are significant. The tag is what remains above
// the index and the word offset.
package icache_pkg;

  localparam int INDEX_BITS = 7;
  localparam int ADDR_USED  = 18;
  localparam int TAG_BITS   = ADDR_USED - 2 - INDEX_BITS;
  localparam int LINES      = 1 << INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [31:0]           word_t;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_FILL = 2'd1,
    ICACHE_RESP = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// icache_if: the two handshakes around the instruction cache.
//
// IF side   : if_pc_get, if_pc_address (to cache); if_done, if_inst (from cache)
// mem side  : mem_get, mem_address (from cache); mem_done, mem_inst (to cache)
//
// Handshake: a requester raises *_get with a stable address and holds both
// until the responder pulses *_done for exactly one cycle, with the data
// valid in that same cycle. The *_done pulse completes the transfer. A new
// request may be presented in the cycle after the pulse.
//
// Modports: slave = the cache, master = the IF stage and memctrl together.
interface icache_if;
  logic        if_pc_get;
  logic [31:0] if_pc_address;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_get;
  logic [31:0] mem_address;
  logic        mem_done;
  logic [31:0] mem_inst;

  modport slave (
    input  if_pc_get, if_pc_address, mem_done, mem_inst,
    output if_done, if_inst, mem_get, mem_address
  );

  modport master (
    output if_pc_get, if_pc_address, mem_done, mem_inst,
    input  if_done, if_inst, mem_get, mem_address
  );
endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the instruction cache.
//
// Ports:
//   clk_in, rst_in, rdy_in : clock, sync active-high reset, global ready
//   rd_index               : asynchronous read index
//   rd_valid/rd_tag/rd_data: contents of line rd_index
//   wr_en, wr_index,
//   wr_tag, wr_data        : synchronous write port; marks the line valid
//
// Valid bits sit in flops so that reset clears every line in one cycle.
// Tags and data have no reset; they are meaningless while valid is low.
module icache_array
  import icache_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   rdy_in,
  input  index_t rd_index,
  output logic   rd_valid,
  output tag_t   rd_tag,
  output word_t  rd_data,
  input  logic   wr_en,
  input  index_t wr_index,
  input  tag_t   wr_tag,
  input  word_t  wr_data
);

  logic [LINES-1:0] valid_q;
  tag_t             tag_mem  [LINES];
  word_t            data_mem [LINES];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (rdy_in && wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // A write coinciding with reset is dropped so a refill abandoned by reset
  // leaves no trace in the array.
  always_ff @(posedge clk_in) begin
    if (rdy_in && wr_en && !rst_in) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between the IF stage and the
// instruction port of memctrl.
//
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   rdy_in         : global ready; when low nothing in the cache changes
//   bus            : icache_if.slave (IF request/response, memctrl refill)
//   dbg_state      : current FSM state, for observation only
//   hit_count_out,
//   miss_count_out : accepted hit/miss counters (only with ICACHE_STAT_EN)
//
// Build option: define ICACHE_STAT_EN to add the hit/miss counters.
//
// Hits answer one cycle after the request is seen. A miss raises mem_get,
// waits for mem_done, writes the line, then spends one RESP cycle answering
// IF if it still wants the same address. After every if_done pulse one
// request cycle is skipped, so a level request is never answered twice.
module icache
  import icache_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  icache_if.slave       bus,
  output icache_state_e dbg_state
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]   hit_count_out,
  output logic [31:0]   miss_count_out
`endif
);

  icache_state_e state;
  logic          if_done_q;
  word_t         if_inst_q;
  logic          mem_get_q;
  word_t         req_addr;

  index_t rd_index;
  tag_t   req_tag;
  word_t  fetch_addr;
  logic   rd_valid;
  tag_t   rd_tag;
  word_t  rd_data;
  logic   hit;
  logic   accept;
  logic   wr_en;
  logic   unused_addr_lsbs;

  assign fetch_addr       = {bus.if_pc_address[31:2], 2'b00};
  assign rd_index         = bus.if_pc_address[INDEX_BITS+1:2];
  assign req_tag          = bus.if_pc_address[ADDR_USED-1:INDEX_BITS+2];
  assign unused_addr_lsbs = &{1'b0, bus.if_pc_address[1:0]};

  assign hit    = rd_valid && (rd_tag == req_tag);
  // if_done high means a response is going out this cycle for the
  // request still on the bus; skip it.
  assign accept = bus.if_pc_get && !if_done_q;
  assign wr_en  = (state == ICACHE_FILL) && bus.mem_done;

  icache_array u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (req_addr[INDEX_BITS+1:2]),
    .wr_tag   (req_addr[ADDR_USED-1:INDEX_BITS+2]),
    .wr_data  (bus.mem_inst)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ICACHE_IDLE;
      if_done_q <= 1'b0;
      if_inst_q <= '0;
      mem_get_q <= 1'b0;
      req_addr  <= '0;
    end else if (rdy_in) begin
      if_done_q <= 1'b0;
      case (state)
        ICACHE_IDLE: begin
          if (accept) begin
            if (hit) begin
              if_done_q <= 1'b1;
              if_inst_q <= rd_data;
            end else begin
              mem_get_q <= 1'b1;
              req_addr  <= fetch_addr;
              state     <= ICACHE_FILL;
            end
          end
        end
        ICACHE_FILL: begin
          // memctrl cannot be cancelled, so the refill always completes
          // even if IF has moved on.
          if (bus.mem_done) begin
            mem_get_q <= 1'b0;
            state     <= ICACHE_RESP;
          end
        end
        ICACHE_RESP: begin
          // The line was written at the edge entering RESP, so the async
          // read at the matching index already returns the new word.
          if (bus.if_pc_get && (fetch_addr == req_addr)) begin
            if_done_q <= 1'b1;
            if_inst_q <= rd_data;
          end
          state <= ICACHE_IDLE;
        end
        default: state <= ICACHE_IDLE;
      endcase
    end
  end

  assign bus.if_done     = if_done_q;
  assign bus.if_inst     = if_inst_q;
  assign bus.mem_get     = mem_get_q;
  assign bus.mem_address = req_addr;
  assign dbg_state       = state;

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (rdy_in && (state == ICACHE_IDLE) && accept) begin
      if (hit) hit_count_q  <= hit_count_q + 32'd1;
      else     miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count_out  = hit_count_q;
  assign miss_count_out = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache. The bench plays both
// the IF stage and memctrl. Inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_icache;
  import icache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  icache_if      bus ();
  icache_state_e dbg_state;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .rdy_in    (rdy),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef ICACHE_STAT_EN
    ,
    .hit_count_out  (hit_count),
    .miss_count_out (miss_count)
`endif
  );

  int n_tests  = 0;
  int n_failed = 0;
  int exp_hits   = 0;
  int exp_misses = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] DATA_D = 32'h00020137;
  localparam logic [31:0] DATA_A = 32'hAAAA0001;
  localparam logic [31:0] DATA_B = 32'hBBBB0002;
  localparam logic [31:0] DATA_C = 32'h0C0C0C0C;
  localparam logic [31:0] DATA_E = 32'hE0E0E0E0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full miss transaction: request, wait for mem_get, reply after two
  // more cycles, wait for if_done, drop the request, idle one cycle.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] data,
                         output bit got_get, output logic [31:0] got_addr,
                         output bit got_done, output logic [31:0] got_inst);
    got_get  = 1'b0;
    got_addr = '0;
    got_done = 1'b0;
    got_inst = '0;
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = addr;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.mem_get) begin
        got_get = 1'b1;
        break;
      end
    end
    if (got_get) begin
      got_addr = bus.mem_address;
      tick();
      tick();
      bus.mem_inst = data;
      bus.mem_done = 1'b1;
      tick();
      bus.mem_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (bus.if_done) begin
          got_done = 1'b1;
          got_inst = bus.if_inst;
          break;
        end
      end
    end
    bus.if_pc_get = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    bus.if_pc_get     = 1'b0;
    bus.if_pc_address = '0;
    bus.mem_done      = 1'b0;
    bus.mem_inst      = '0;
    tick();
    tick();
    n_tests++;
    if ({bus.if_done, bus.mem_get} !== 2'b00 || bus.if_inst !== 32'h0 ||
        bus.mem_address !== 32'h0 || dbg_state !== ICACHE_IDLE) begin
      n_failed++;
      $display("FAIL reset_outputs: if_done=%b mem_get=%b if_inst=%h mem_address=%h state=%0d, expected 0 0 0 0 IDLE",
               bus.if_done, bus.mem_get, bus.if_inst, bus.mem_address, dbg_state);
    end
    rst = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    tick();
    n_tests++;
    if (bus.if_done !== 1'b0 || bus.mem_get !== 1'b0) begin
      n_failed++;
      $display("FAIL reset_idle: if_done=%b mem_get=%b, expected 0 0", bus.if_done, bus.mem_get);
    end
  endtask

  task automatic test_miss_fill();
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = 32'h0;
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || bus.mem_address !== 32'h0 || bus.if_done !== 1'b0 ||
        dbg_state !== ICACHE_FILL) begin
      n_failed++;
      $display("FAIL miss_request: mem_get=%b mem_address=%h if_done=%b state=%0d, expected 1 00000000 0 FILL",
               bus.mem_get, bus.mem_address, bus.if_done, dbg_state);
    end
    exp_misses++;
    tick();
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || bus.mem_address !== 32'h0) begin
      n_failed++;
      $display("FAIL miss_hold: mem_get=%b mem_address=%h, expected 1 00000000", bus.mem_get, bus.mem_address);
    end
    bus.mem_inst = DATA_D;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    n_tests++;
    if (bus.mem_get !== 1'b0 || bus.if_done !== 1'b0 || dbg_state !== ICACHE_RESP) begin
      n_failed++;
      $display("FAIL miss_enter_resp: mem_get=%b if_done=%b state=%0d, expected 0 0 RESP",
               bus.mem_get, bus.if_done, dbg_state);
    end
    tick();
    n_tests++;
    if (bus.if_done !== 1'b1 || bus.if_inst !== DATA_D || dbg_state !== ICACHE_IDLE) begin
      n_failed++;
      $display("FAIL miss_response: if_done=%b if_inst=%h state=%0d, expected 1 %h IDLE",
               bus.if_done, bus.if_inst, dbg_state, DATA_D);
    end
`ifdef ICACHE_STAT_EN
    n_tests++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      n_failed++;
      $display("FAIL miss_counters: hits=%0d misses=%0d, expected %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  // Request for 0x0 stays up after the miss response.
  task automatic test_hit_after_bubble();
    tick();
    n_tests++;
    if (bus.if_done !== 1'b0) begin
      n_failed++;
      $display("FAIL hit_bubble: if_done=%b, expected 0", bus.if_done);
    end
    tick();
    n_tests++;
    if (bus.if_done !== 1'b1 || bus.if_inst !== DATA_D || bus.mem_get !== 1'b0) begin
      n_failed++;
      $display("FAIL hit_response: if_done=%b if_inst=%h mem_get=%b, expected 1 %h 0",
               bus.if_done, bus.if_inst, bus.mem_get, DATA_D);
    end
    exp_hits++;
    bus.if_pc_get = 1'b0;
    tick();
    n_tests++;
    if (bus.if_done !== 1'b0) begin
      n_failed++;
      $display("FAIL hit_single_pulse: if_done=%b, expected 0", bus.if_done);
    end
`ifdef ICACHE_STAT_EN
    n_tests++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      n_failed++;
      $display("FAIL hit_counters: hits=%0d misses=%0d, expected %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_conflict();
    bit          g_get, g_done;
    logic [31:0] g_addr, g_inst;
    do_miss(32'h4, DATA_A, g_get, g_addr, g_done, g_inst);
    exp_misses++;
    n_tests++;
    if (!g_get || g_addr !== 32'h4 || !g_done || g_inst !== DATA_A) begin
      n_failed++;
      $display("FAIL conflict_fill_a: get=%b addr=%h done=%b inst=%h, expected 1 00000004 1 %h",
               g_get, g_addr, g_done, g_inst, DATA_A);
    end
    do_miss(32'h204, DATA_B, g_get, g_addr, g_done, g_inst);
    exp_misses++;
    n_tests++;
    if (!g_get || g_addr !== 32'h204 || !g_done || g_inst !== DATA_B) begin
      n_failed++;
      $display("FAIL conflict_fill_b: get=%b addr=%h done=%b inst=%h, expected 1 00000204 1 %h",
               g_get, g_addr, g_done, g_inst, DATA_B);
    end
    do_miss(32'h4, DATA_A, g_get, g_addr, g_done, g_inst);
    exp_misses++;
    n_tests++;
    if (!g_get || g_addr !== 32'h4 || !g_done || g_inst !== DATA_A) begin
      n_failed++;
      $display("FAIL conflict_evicted: get=%b addr=%h done=%b inst=%h, expected 1 00000004 1 %h",
               g_get, g_addr, g_done, g_inst, DATA_A);
    end
  endtask

  task automatic test_redirect();
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = 32'h100;
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || bus.mem_address !== 32'h100) begin
      n_failed++;
      $display("FAIL redirect_miss: mem_get=%b mem_address=%h, expected 1 00000100", bus.mem_get, bus.mem_address);
    end
    exp_misses++;
    bus.if_pc_address = 32'h200;
    tick();
    bus.mem_inst = DATA_C;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    tick();
    n_tests++;
    if (bus.if_done !== 1'b0 || bus.mem_get !== 1'b0 || dbg_state !== ICACHE_IDLE) begin
      n_failed++;
      $display("FAIL redirect_drop: if_done=%b mem_get=%b state=%0d, expected 0 0 IDLE",
               bus.if_done, bus.mem_get, dbg_state);
    end
    bus.if_pc_get = 1'b0;
    tick();
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = 32'h100;
    tick();
    n_tests++;
    if (bus.if_done !== 1'b1 || bus.if_inst !== DATA_C || bus.mem_get !== 1'b0) begin
      n_failed++;
      $display("FAIL redirect_line_kept: if_done=%b if_inst=%h mem_get=%b, expected 1 %h 0",
               bus.if_done, bus.if_inst, bus.mem_get, DATA_C);
    end
    exp_hits++;
    bus.if_pc_get = 1'b0;
    tick();
  endtask

  task automatic test_rdy_stall();
    int bad;
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = 32'h300;
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || bus.mem_address !== 32'h300) begin
      n_failed++;
      $display("FAIL stall_miss: mem_get=%b mem_address=%h, expected 1 00000300", bus.mem_get, bus.mem_address);
    end
    exp_misses++;
    rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_get !== 1'b1 || bus.mem_address !== 32'h300 || bus.if_done !== 1'b0 ||
          dbg_state !== ICACHE_FILL) bad++;
`ifdef ICACHE_STAT_EN
      if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) bad++;
`endif
    end
    n_tests++;
    if (bad != 0) begin
      n_failed++;
      $display("FAIL stall_frozen: %0d cycles changed while rdy low, expected 0", bad);
    end
    rdy = 1'b1;
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || dbg_state !== ICACHE_FILL) begin
      n_failed++;
      $display("FAIL stall_resume_hold: mem_get=%b state=%0d, expected 1 FILL", bus.mem_get, dbg_state);
    end
    bus.mem_inst = DATA_E;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    tick();
    n_tests++;
    if (bus.if_done !== 1'b1 || bus.if_inst !== DATA_E) begin
      n_failed++;
      $display("FAIL stall_response: if_done=%b if_inst=%h, expected 1 %h", bus.if_done, bus.if_inst, DATA_E);
    end
    bus.if_pc_get = 1'b0;
    tick();
  endtask

  // Consecutive hits on different lines; 0x00040004 aliases 0x4 because
  // bits above ADDR_USED are ignored.
  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp_inst;
    int bubble_bad;
    addrs = '{32'h0, 32'h4, 32'h00040004, 32'h300};
    exp_q.push_back(DATA_D);
    exp_q.push_back(DATA_A);
    exp_q.push_back(DATA_A);
    exp_q.push_back(DATA_E);
    bubble_bad = 0;
    bus.if_pc_get = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.if_pc_address = addrs[i];
      if (i > 0) begin
        tick();
        if (bus.if_done !== 1'b0) bubble_bad++;
      end
      tick();
      exp_inst = exp_q.pop_front();
      n_tests++;
      if (bus.if_done !== 1'b1 || bus.if_inst !== exp_inst || bus.mem_get !== 1'b0) begin
        n_failed++;
        $display("FAIL b2b_hit[%0d]: addr=%h if_done=%b if_inst=%h mem_get=%b, expected 1 %h 0",
                 i, addrs[i], bus.if_done, bus.if_inst, bus.mem_get, exp_inst);
      end
      exp_hits++;
    end
    n_tests++;
    if (bubble_bad != 0) begin
      n_failed++;
      $display("FAIL b2b_bubble: %0d bubble cycles had if_done=1, expected 0", bubble_bad);
    end
    bus.if_pc_get = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_fill();
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = 32'h8;
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || bus.mem_address !== 32'h8) begin
      n_failed++;
      $display("FAIL rif_miss: mem_get=%b mem_address=%h, expected 1 00000008", bus.mem_get, bus.mem_address);
    end
    rst = 1'b1;
    bus.if_pc_get = 1'b0;
    tick();
    rst = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    n_tests++;
    if (bus.mem_get !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_address !== 32'h0 ||
        dbg_state !== ICACHE_IDLE) begin
      n_failed++;
      $display("FAIL rif_abandon: mem_get=%b if_done=%b mem_address=%h state=%0d, expected 0 0 00000000 IDLE",
               bus.mem_get, bus.if_done, bus.mem_address, dbg_state);
    end
    bus.mem_inst = 32'hBAD0BAD0;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    n_tests++;
    if (bus.mem_get !== 1'b0 || bus.if_done !== 1'b0 || dbg_state !== ICACHE_IDLE) begin
      n_failed++;
      $display("FAIL rif_late_done: mem_get=%b if_done=%b state=%0d, expected 0 0 IDLE",
               bus.mem_get, bus.if_done, dbg_state);
    end
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = 32'h0;
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || bus.mem_address !== 32'h0 || bus.if_done !== 1'b0) begin
      n_failed++;
      $display("FAIL rif_line_cleared: mem_get=%b mem_address=%h if_done=%b, expected 1 00000000 0",
               bus.mem_get, bus.mem_address, bus.if_done);
    end
    exp_misses++;
    bus.mem_inst = DATA_D;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    tick();
    n_tests++;
    if (bus.if_done !== 1'b1 || bus.if_inst !== DATA_D) begin
      n_failed++;
      $display("FAIL rif_refill: if_done=%b if_inst=%h, expected 1 %h", bus.if_done, bus.if_inst, DATA_D);
    end
    bus.if_pc_get = 1'b0;
    tick();
    bus.if_pc_get     = 1'b1;
    bus.if_pc_address = 32'h8;
    tick();
    n_tests++;
    if (bus.mem_get !== 1'b1 || bus.if_done !== 1'b0) begin
      n_failed++;
      $display("FAIL rif_late_not_written: mem_get=%b if_done=%b, expected 1 0", bus.mem_get, bus.if_done);
    end
    exp_misses++;
    bus.mem_inst = 32'h00000013;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    tick();
    bus.if_pc_get = 1'b0;
    tick();
`ifdef ICACHE_STAT_EN
    n_tests++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      n_failed++;
      $display("FAIL rif_counters: hits=%0d misses=%0d, expected %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.if_pc_get     = 1'b0;
    bus.if_pc_address = '0;
    bus.mem_done      = 1'b0;
    bus.mem_inst      = '0;
    test_reset();
    test_miss_fill();
    test_hit_after_bubble();
    test_conflict();
    test_redirect();
    test_rdy_stall();
    test_back_to_back();
    test_reset_in_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
